fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end that drives the word address of the combinational instruction ROM and hands fetched instructions to decode. It holds the fetch PC, buffers instruction/PC pairs in a small prefetch FIFO, and applies a valid/ready handshake toward decode. Redirects from execute, such as branches and jumps, flush the FIFO and restart fetch. It sits between the instruction memory and the decode stage.

## Interface
- XLEN, 32, instruction and PC width
- ADDR_WIDTH, 8, instruction memory word-address width
- RESET_PC, 32'h0000_0000, fetch PC after reset
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_WIDTH  ROM word address, equal to fetch_pc[ADDR_WIDTH+1:2]
- imem_rd  in  XLEN  ROM data, combinational from imem_addr in the same cycle
- redirect_valid  in  1  flush the FIFO and load a new fetch PC
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts the head
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  head PC
- out_fault  out  1  head is a misaligned-fetch marker; present only with FETCH_MISALIGN_TRAP_EN

## Operation
- State:
  - fetch_pc: XLEN bits
  - FIFO: FIFO_DEPTH entries, each holding {pc, instr, fault}
  - count: $clog2(FIFO_DEPTH+1) bits
  - halted flag
- pop = out_valid && out_ready.
- push = !reset && !redirect_valid && !halted && (count < FIFO_DEPTH || pop).
  - A push into a full FIFO is allowed in the same cycle as a pop.
- On push:
  - Write entry {fetch_pc, imem_rd, 0}.
  - Update fetch_pc <= fetch_pc + 4, mod 2^XLEN.
  - The ROM index wraps naturally mod 2^ADDR_WIDTH because only bits [ADDR_WIDTH+1:2] are used.
- On redirect_valid:
  - Set count to 0 and reset the FIFO pointers.
  - Set fetch_pc <= redirect_pc and clear halted.
  - No push occurs that cycle.
  - A pop in the same cycle counts as accepted by decode, but the flush wins for FIFO state.
- Redirect has priority over push and pop. Reset has priority over everything.
- out_valid = (count != 0).
- out_instr, out_pc and out_fault are forced to 0 whenever out_valid = 0.
- Without the macro, fetch_pc[1:0] is forced to 0 on every load, so halted stays 0.

## Timing
- Reset values:
  - out_valid = 0, out_instr = 0, out_pc = 0, out_fault = 0
  - fetch_pc = RESET_PC
  - imem_addr = RESET_PC[ADDR_WIDTH+1:2]
  - count = 0, halted = 0
- First cycle after reset deasserts (cycle 0): imem_addr presents RESET_PC and the entry is pushed at the edge.
  - Cycle 1: out_valid = 1, out_pc = RESET_PC.
- Redirect sampled at edge N:
  - Cycle N+1: out_valid = 0 and imem_addr presents the target; the push happens at the end of the cycle.
  - Cycle N+2: out_valid = 1 with out_pc = redirect_pc.
- Steady state with out_ready held at 1: one instruction per cycle, and the FIFO never fills.
- With out_ready held at 0: the FIFO fills in FIFO_DEPTH cycles, then fetch_pc and imem_addr hold.
- Head data stays stable while out_valid = 1 and out_ready = 0.
- Fetch-to-decode latency is 1 cycle. The FIFO has no combinational bypass.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - If a loaded PC (redirect or RESET_PC) has bits [1:0] != 0, the next push writes {pc, 32'h0000_0013, fault = 1} and sets halted.
  - No further pushes occur until the next redirect.
  - out_fault port is present.
- FETCH_MISALIGN_TRAP_EN undefined:
  - PC bits [1:0] are cleared on load.
  - No out_fault port and no halted logic.

## Structure
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013
  - fetch_entry_t packed struct {pc, instr, fault}
  - PC_STEP = 4
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Provides push, pop and flush; exposes count, full and empty.
- fetch_unit holds fetch_pc, the push/halt control and the output gating.

## Test plan
- Reset with RESET_PC = 0 and out_ready = 1; ROM holds word i = 0x1000+i -> from cycle 1, out_pc = 0, 4, 8… and out_instr = 0x1000, 0x1001… on consecutive cycles.
- Hold out_ready = 0 for 8 cycles -> count reaches 4 and imem_addr holds at 4; release -> out_pc = 0, 4, 8, 12, 16 in order, no gaps or duplicates.
- Assert redirect_valid with redirect_pc = 0x40 while the FIFO holds 3 entries -> out_valid = 0 the next cycle, then out_pc = 0x40 and out_instr = ROM[16].
- FIFO full with out_ready = 1 -> one push and one pop per cycle, count stays 4.
- fetch_pc = 0x3FC (ROM word 255) -> next entry has out_pc = 0x400 and out_instr = ROM[0].
- Under FETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> one entry {pc 0x42, instr 0x13, fault 1}, then out_valid stays 0 until a redirect to 0x44 resumes fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with push, pop and flush.
// Reset and flush both empty it; a push into a full FIFO is legal only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, prefetch FIFO and valid/ready toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned-PC fault marker and halt).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               ADDR_WIDTH = 8,
  parameter logic [XLEN-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]       imem_rd,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_instr,
  output logic [XLEN-1:0]       out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  out_fault
`endif
);

  logic [XLEN-1:0]                 fetch_pc;
  logic                            halted;
  logic                            push;
  logic                            pop;
  fetch_entry_t                    wr_entry;
  fetch_entry_t                    head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic                            fifo_full;
  logic                            fifo_empty;

  // Without the trap feature a loaded PC is forced word-aligned.
  function automatic logic [XLEN-1:0] load_pc(input logic [XLEN-1:0] pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    return pc;
`else
    return {pc[XLEN-1:2], 2'b00};
`endif
  endfunction

  assign imem_addr = fetch_pc[ADDR_WIDTH+1:2];

  // Handshake decode and the entry written on a push.
  always_comb begin
    pop            = !fifo_empty && out_ready;
    push           = !reset && !redirect_valid && !halted && (!fifo_full || pop);
    wr_entry.pc    = fetch_pc;
    wr_entry.instr = imem_rd;
    wr_entry.fault = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (fetch_pc[1:0] != 2'b00) begin
      wr_entry.instr = NOP_INSTR;
      wr_entry.fault = 1'b1;
    end else begin
      wr_entry.fault = 1'b0;
    end
`endif
  end

  // Fetch PC: reset beats redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= load_pc(RESET_PC);
    end else if (redirect_valid) begin
      fetch_pc <= load_pc(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + XLEN'(PC_STEP);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Halt after emitting a fault marker until the next redirect.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      halted <= 1'b0;
    end else if (push && wr_entry.fault) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output gating: head fields read as zero whenever nothing is valid.
  always_comb begin
    out_valid = (fifo_count != '0);
    out_pc    = '0;
    out_instr = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    out_fault = 1'b0;
`endif
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
      out_fault = head.fault;
`endif
    end else begin
      out_pc    = '0;
      out_instr = '0;
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  logic head_fault_unused;
  assign head_fault_unused = head.fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random ready/redirect
// traffic, checked against a queue-based model of the prefetch buffer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        out_fault;
`endif

  logic [31:0] rom [256];
  assign imem_rd = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .out_fault      (out_fault)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } m_entry_t;

  m_entry_t    mq [$];
  logic [31:0] mpc;
  logic        mhalt;
  int          n_checks = 0;
  int          n_bad    = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rp);
    logic        ev;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        ef;
    logic [31:0] widx;
    @(negedge clk);
    ev = (mq.size() != 0);
    ep = ev ? mq[0].pc : 32'h0;
    ei = ev ? mq[0].instr : 32'h0;
    ef = ev ? mq[0].fault : 1'b0;
    widx = {22'h0, mpc[9:2]};
    check_value("out_valid", 32'(out_valid), 32'(ev));
    check_value("out_pc", out_pc, ep);
    check_value("out_instr", out_instr, ei);
    check_value("imem_addr", 32'(imem_addr), widx);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_value("out_fault", 32'(out_fault), 32'(ef));
`endif
    reset          = 1'b0;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    if (rv) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      mpc = rp;
`else
      mpc = rp & 32'hFFFF_FFFC;
`endif
      mhalt = 1'b0;
    end else begin
      if (ev && rdy) begin
        void'(mq.pop_front());
      end
      if (!mhalt && mq.size() < 4) begin
        if (mpc[1:0] != 2'b00) begin
          mq.push_back('{mpc, 32'h0000_0013, 1'b1});
          mhalt = 1'b1;
        end else begin
          mq.push_back('{mpc, rom[mpc[9:2]], 1'b0});
        end
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 32'h0000_1000 + 32'(i);
    end
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mq.delete();
    mpc   = 32'h0;
    mhalt = 1'b0;
    repeat (3) @(posedge clk);

    // Streaming from reset, then stall to fill, then drain in order.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)  step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 32'h0);

    // Redirect while the FIFO holds a few entries.
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 32'h0);

    // Full FIFO with ready: simultaneous push and pop.
    for (int i = 0; i < 6; i++)  step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 32'h0);

    // ROM index wrap past word 255.
    step(1'b1, 1'b1, 32'h0000_03F4);
    for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then an aligned one, plus redirect coinciding with a pop.
    step(1'b1, 1'b1, 32'h0000_0042);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0044);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        v;
      logic [31:0] t;
      r = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_07FF) : $urandom;
      step(r, v, t);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
